demux1x8_collector: RTL and testbench
=====================================

// Module: demux1x8_collector
// PURPOSE
//  Sequential 1-to-8 demultiplexer and frame collector: the inverse of mux8x1.
//  Accepts single-bit beats {s, d} over a valid/ready handshake.
//  Steers each bit into lane e[s] and tracks which lanes have been written.
//  Once all 8 lanes are filled, presents the frame e[7:0] on a valid/ready output.
//  Pairs with mux8x1 in a loopback: mux8x1 serialises a byte by select, this block rebuilds it.
// PARAMETERS
//  LANES   8   number of output lanes; fixed at 8 in this revision (SEL_W = 3)
//  RST_VAL 0   value loaded into e[7:0] at reset and after each frame handoff/flush
// PORTS
//  clk        in   1  rising-edge clock
//  rst        in   1  asynchronous, active-high reset
//  in_valid   in   1  beat {s,d} offered this cycle
//  in_ready   out  1  block can accept a beat this cycle
//  s          in   3  destination lane select
//  d          in   1  data bit for lane s
//  flush      in   1  synchronous abort: discard partial frame
//  out_valid  out  1  complete frame held on e
//  out_ready  in   1  consumer takes frame this cycle
//  e          out  8  collected frame; bit i = last d written with s==i
//  written    out  8  lane-filled mask; bit i set once lane i written this frame
//  dup_err    out  1  one-cycle pulse: accepted beat hit an already-written lane
// BEHAVIOUR
//  Reset (async, rst=1):
//   - state=COLLECT, e=RST_VAL, written=0, out_valid=0, dup_err=0.
//   - in_ready=1 as soon as rst deasserts.
//  Beat accepted on a clock edge where in_valid & in_ready are both 1.
//  FSM, two states:
//   COLLECT: in_ready=1, out_valid=0.
//    - Accepted beat: e[s]<=d, written[s]<=1 on the same edge (1-cycle latency).
//    - If (written | onehot(s)) == 8'hFF after the write, go to HOLD next cycle.
//   HOLD: in_ready=0, out_valid=1; e and written are frozen.
//    - out_valid & out_ready: e<=RST_VAL, written<=0, go to COLLECT.
//    - Input is not accepted in the handoff cycle even if in_valid=1 (in_ready=0).
//  Duplicate lane: accepted beat with written[s]==1 in COLLECT.
//   - Overwrites e[s]; mask is unchanged.
//   - dup_err=1 for exactly the following cycle.
//  flush (sync, checked every edge): e<=RST_VAL, written<=0, state<=COLLECT, out_valid<=0.
//   - Priority: rst > flush > handshake.
//   - A beat offered in the flush cycle is discarded and does not set dup_err.
//  Frame completion is order-independent: any permutation of the 8 lanes completes it.
//   - Minimum 8 accepted beats per frame.
//  Throughput: 8 beats plus 1 handoff cycle per frame, with out_ready held high.
//  rst mid-frame or in HOLD: all outputs return to reset values immediately (asynchronous).
//  X on s or d while in_valid=0 is ignored.
// TESTING
//  1. Reset, then s=0..7 with d=10110010 (LSB first), in_valid=1 back-to-back, out_ready=1.
//     -> out_valid on cycle 9, e=8'h4D, written=8'hFF.
//     -> in_ready=0 for that one cycle, then e=0.
//  2. Same lanes in order 7,0,6,1,5,2,4,3, all d=1, out_ready=0 for 5 cycles.
//     -> e=8'hFF and out_valid held stable for 5 cycles.
//     -> in_valid beats during HOLD are not accepted.
//  3. Write s=3 d=1, then s=3 d=0.
//     -> dup_err pulses once, e[3]=0, written=8'h08.
//  4. After 5 beats (written=8'h1F), assert flush together with in_valid s=5.
//     -> next cycle written=0, e=0, no dup_err, state COLLECT.
//  5. Assert rst asynchronously mid-cycle while in HOLD.
//     -> out_valid, e and written drop to 0 before the next clk edge.
//  6. Loopback vs mux8x1: 500 random bytes, serialised as s=0..7 through mux8x1.
//     -> every collected e matches the source byte, dup_err never asserts.

Source files
------------

// File: rtl/demux1x8_collector.sv
// Sequential 1-to-8 demultiplexer: steers single-bit beats into lanes and hands
// off the assembled frame once every lane has been written.
module demux1x8_collector #(
    parameter int              LANES   = 8,
    parameter logic [LANES-1:0] RST_VAL = '0,
    localparam int             SEL_W   = $clog2(LANES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SEL_W-1:0] s,
    input  logic             d,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [LANES-1:0] e,
    output logic [LANES-1:0] written,
    output logic             dup_err
);

    typedef enum logic {COLLECT, HOLD} state_t;

    state_t           state_q;
    logic [LANES-1:0] e_q, e_d;
    logic [LANES-1:0] written_q, written_d;
    logic [LANES-1:0] onehot;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             dup_err_q;
    logic             accept;

    // Candidate lane update; only committed when a beat is actually accepted.
    always_comb begin
        onehot    = '0;
        onehot[s] = 1'b1;
        accept    = in_valid & in_ready_q;
        written_d = written_q | onehot;
        e_d       = e_q;
        e_d[s]    = d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= COLLECT;
            e_q         <= RST_VAL;
            written_q   <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            dup_err_q   <= 1'b0;
        end else begin
            dup_err_q <= 1'b0;
            if (flush) begin
                state_q     <= COLLECT;
                e_q         <= RST_VAL;
                written_q   <= '0;
                in_ready_q  <= 1'b1;
                out_valid_q <= 1'b0;
            end else begin
                case (state_q)
                    COLLECT: begin
                        if (accept) begin
                            e_q       <= e_d;
                            written_q <= written_d;
                            dup_err_q <= written_q[s];
                            // Completion depends only on the mask, so any lane order works.
                            if (&written_d) begin
                                state_q     <= HOLD;
                                in_ready_q  <= 1'b0;
                                out_valid_q <= 1'b1;
                            end
                        end
                    end
                    HOLD: begin
                        if (out_ready) begin
                            state_q     <= COLLECT;
                            e_q         <= RST_VAL;
                            written_q   <= '0;
                            in_ready_q  <= 1'b1;
                            out_valid_q <= 1'b0;
                        end
                    end
                    default: state_q <= COLLECT;
                endcase
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign e         = e_q;
    assign written   = written_q;
    assign dup_err   = dup_err_q;

endmodule

// File: tb/tb_demux1x8_collector.sv
// Bench for demux1x8_collector: directed vectors, a step table and a random loopback
// through a behavioural mux8x1, with completed frames checked against a scoreboard.
module tb_demux1x8_collector;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] s;
    logic       d;
    logic       flush;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] e;
    logic [7:0] written;
    logic       dup_err;

    int errors = 0;
    int checks = 0;
    int dup_seen = 0;
    int frames_rx = 0;
    int frames_tx = 0;
    logic [7:0] exp_q[$];

    demux1x8_collector dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .s(s), .d(d), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .e(e), .written(written), .dup_err(dup_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Frame monitor: inputs change just after posedge, so the negedge sees what the next edge will.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            frames_rx++;
            if (exp_q.size() == 0) begin
                chk("unexpected_frame", e, 8'hxx);
            end else begin
                chk("frame_data", e, exp_q.pop_front());
            end
        end
        if (!rst && dup_err) dup_seen++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [2:0] sel, input logic bit_in);
        int guard;
        guard    = 0;
        s        = sel;
        d        = bit_in;
        in_valid = 1'b1;
        while (!in_ready && guard < 20) begin
            tick();
            guard++;
        end
        if (guard >= 20) chk("in_ready_timeout", {7'd0, in_ready}, 8'h01);
        tick();
        in_valid = 1'b0;
        s        = 3'bxxx;
        d        = 1'bx;
    endtask

    typedef struct {
        logic       vld;
        logic [2:0] sel;
        logic       dat;
        logic       fl;
        logic [7:0] ew;
        logic [7:0] ee;
        logic       edup;
    } vec_t;

    vec_t tbl[10];

    logic [7:0] src;
    logic [7:0] d_pat;
    logic [2:0] order[8];

    initial begin
        // Duplicate-lane and flush sequence, each row checked one edge after it is driven.
        tbl[0] = '{1'b1, 3'd3, 1'b1, 1'b0, 8'h08, 8'h08, 1'b0};
        tbl[1] = '{1'b1, 3'd3, 1'b0, 1'b0, 8'h08, 8'h00, 1'b1};
        tbl[2] = '{1'b0, 3'd0, 1'b0, 1'b0, 8'h08, 8'h00, 1'b0};
        tbl[3] = '{1'b1, 3'd0, 1'b1, 1'b0, 8'h09, 8'h01, 1'b0};
        tbl[4] = '{1'b1, 3'd1, 1'b1, 1'b0, 8'h0B, 8'h03, 1'b0};
        tbl[5] = '{1'b1, 3'd2, 1'b0, 1'b0, 8'h0F, 8'h03, 1'b0};
        tbl[6] = '{1'b1, 3'd4, 1'b1, 1'b0, 8'h1F, 8'h13, 1'b0};
        tbl[7] = '{1'b1, 3'd5, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0};
        tbl[8] = '{1'b1, 3'd5, 1'b0, 1'b0, 8'h20, 8'h00, 1'b0};
        tbl[9] = '{1'b1, 3'd5, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0};

        rst = 1'b1; in_valid = 1'b0; s = 3'd0; d = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst_in_ready", {7'd0, in_ready}, 8'h01);
        chk("rst_out_valid", {7'd0, out_valid}, 8'h00);
        chk("rst_e", e, 8'h00);
        chk("rst_written", written, 8'h00);
        chk("rst_dup", {7'd0, dup_err}, 8'h00);

        // Test 1: in-order frame, d = 10110010 LSB first -> 8'h4D.
        d_pat = 8'h4D;
        exp_q.push_back(8'h4D); frames_tx++;
        for (int i = 0; i < 8; i++) begin
            beat(3'(i), d_pat[i]);
            if (i == 6) chk("t1_not_done_at7", {7'd0, out_valid}, 8'h00);
        end
        chk("t1_out_valid", {7'd0, out_valid}, 8'h01);
        chk("t1_in_ready_hold", {7'd0, in_ready}, 8'h00);
        chk("t1_e", e, 8'h4D);
        chk("t1_written", written, 8'hFF);
        tick();
        chk("t1_after_out_valid", {7'd0, out_valid}, 8'h00);
        chk("t1_after_e", e, 8'h00);
        chk("t1_after_written", written, 8'h00);
        chk("t1_after_in_ready", {7'd0, in_ready}, 8'h01);

        // Test 2: permuted order, consumer stalls 5 cycles while beats are offered.
        order = '{3'd7, 3'd0, 3'd6, 3'd1, 3'd5, 3'd2, 3'd4, 3'd3};
        out_ready = 1'b0;
        exp_q.push_back(8'hFF); frames_tx++;
        for (int i = 0; i < 8; i++) beat(order[i], 1'b1);
        s = 3'd0; d = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("t2_hold_valid", {7'd0, out_valid}, 8'h01);
            chk("t2_hold_e", e, 8'hFF);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("t2_release_valid", {7'd0, out_valid}, 8'h00);
        chk("t2_release_e", e, 8'h00);

        // Tests 3 and 4: table of single-cycle steps.
        for (int i = 0; i < 10; i++) begin
            in_valid = tbl[i].vld;
            s        = tbl[i].sel;
            d        = tbl[i].dat;
            flush    = tbl[i].fl;
            tick();
            chk($sformatf("tbl%0d_written", i), written, tbl[i].ew);
            chk($sformatf("tbl%0d_e", i), e, tbl[i].ee);
            chk($sformatf("tbl%0d_dup", i), {7'd0, dup_err}, {7'd0, tbl[i].edup});
            chk($sformatf("tbl%0d_in_ready", i), {7'd0, in_ready}, 8'h01);
        end
        in_valid = 1'b0; flush = 1'b0;
        tick();

        // Test 5: async reset while holding a frame.
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) beat(3'(i), 1'b1);
        chk("t5_pre_valid", {7'd0, out_valid}, 8'h01);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("t5_async_valid", {7'd0, out_valid}, 8'h00);
        chk("t5_async_e", e, 8'h00);
        chk("t5_async_written", written, 8'h00);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        tick();

        // Test 6: loopback through a behavioural mux8x1 (d = byte[s]).
        dup_seen = 0;
        for (int n = 0; n < 500; n++) begin
            src = 8'($urandom);
            exp_q.push_back(src); frames_tx++;
            for (int i = 0; i < 8; i++) beat(3'(i), src[i]);
        end
        repeat (3) tick();
        chk("t6_dup_never", 8'(dup_seen), 8'h00);
        chk("sb_drained", 8'(exp_q.size()), 8'h00);
        checks++;
        if (frames_rx != frames_tx) begin
            errors++;
            $display("FAIL frames_count: got %0d expected %0d", frames_rx, frames_tx);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
